// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard
//   Result-consuming stage sitting behind the fpu and the golden-model checker.
//   Every issued operation is captured together with its golden result in an
//   expectation FIFO. A LATENCY-deep "due" shift register marks the cycle in
//   which the fpu result for that issue is on in_fpuout. In that cycle the FIFO
//   head is popped and compared. The block keeps pass/fail statistics, captures
//   the first mismatch, and runs a drain/verdict FSM once the generator ends.
//
//   Parameters
//     LATENCY  cycles from issue to valid fpu result (1..DEPTH)
//     DEPTH    expectation FIFO entries (power of two)
//     CNT_W    statistic counter width
//
//   Ports
//     clk, reset             clock, synchronous active-high reset
//     in_valid, in_op,
//     in_opA, in_opB         issued operation
//     in_golden              golden result, valid alongside in_valid
//     in_fpuout              raw fpu result bus
//     in_end                 generator finished issuing (pulse)
//     checks_cnt, fail_cnt   comparisons performed / mismatches (saturating)
//     first_fail_*           sticky capture of the first mismatch
//     sb_err                 sticky FIFO overflow/underflow or late issue
//     done, pass             verdict
//     op_fail_cnt            per-op mismatch counters, 8 x CNT_W
//                            (only when FPU_SB_OPHIST_EN is defined)
module fpu_scoreboard #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    input  logic [31:0]       in_opA,
    input  logic [31:0]       in_opB,
    input  logic [31:0]       in_golden,
    input  logic [31:0]       in_fpuout,
    input  logic              in_end,
    output logic [CNT_W-1:0]  checks_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_valid,
    output logic [2:0]        first_fail_op,
    output logic [31:0]       first_fail_opA,
    output logic [31:0]       first_fail_opB,
    output logic [31:0]       first_fail_exp,
    output logic [31:0]       first_fail_got,
    output logic              sb_err,
    output logic              done,
    output logic              pass
`ifdef FPU_SB_OPHIST_EN
    ,
    output logic [8*CNT_W-1:0] op_fail_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 3 + 32 * 3;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Bit-exact, or any NaN against any NaN, or +0 against -0.
    function automatic logic fp_match(input logic [31:0] exp_v, input logic [31:0] got_v);
        return (exp_v == got_v)
            || (is_nan(exp_v) && is_nan(got_v))
            || (is_zero(exp_v) && is_zero(got_v));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [LATENCY-1:0] due_pipe;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic              accepting;
    logic              issue;
    logic              ignored_issue;
    logic              due;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              underflow;
    logic              mismatch;
    logic [EW-1:0]     head;
    logic [2:0]        head_op;
    logic [31:0]       head_opA;
    logic [31:0]       head_opB;
    logic [31:0]       head_golden;

    // Issues are only taken while the generator is still running; anything
    // arriving during drain or after the verdict is a protocol error.
    assign accepting     = (state == S_IDLE) || (state == S_RUN);
    assign issue         = in_valid && accepting;
    assign ignored_issue = in_valid && !accepting;

    assign due   = due_pipe[LATENCY-1];
    assign empty = (count == '0);
    assign full  = (count == FULL_LVL);

    // A same-cycle pop frees the slot, so a push into a full FIFO is still
    // legal when the head is leaving.
    assign pop       = due && !empty;
    assign push      = issue && (!full || pop);
    assign overflow  = issue && full && !pop;
    assign underflow = due && empty;

    assign head        = mem[rd_ptr];
    assign head_op     = head[98:96];
    assign head_opA    = head[95:64];
    assign head_opB    = head[63:32];
    assign head_golden = head[31:0];
    assign mismatch    = pop && !fp_match(head_golden, in_fpuout);

    // Issue stage: due shift register. The due pulse tracks every accepted
    // issue, including ones dropped on overflow, so the underflow that follows
    // a dropped entry is also flagged.
    generate
        if (LATENCY == 1) begin : g_due_one
            always_ff @(posedge clk) begin
                if (reset) due_pipe <= '0;
                else       due_pipe <= issue;
            end
        end else begin : g_due_many
            always_ff @(posedge clk) begin
                if (reset) due_pipe <= '0;
                else       due_pipe <= {due_pipe[LATENCY-2:0], issue};
            end
        end
    endgenerate

    // Expectation storage: payload only, validity is carried by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_op, in_opA, in_opB, in_golden};
    end

    // Compare stage: FIFO control, statistics and first-mismatch capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            checks_cnt       <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_op    <= '0;
            first_fail_opA   <= '0;
            first_fail_opB   <= '0;
            first_fail_exp   <= '0;
            first_fail_got   <= '0;
            sb_err           <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
            if (pop) checks_cnt <= sat_inc(checks_cnt);
            if (mismatch) begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_op    <= head_op;
                    first_fail_opA   <= head_opA;
                    first_fail_opB   <= head_opB;
                    first_fail_exp   <= head_golden;
                    first_fail_got   <= in_fpuout;
                end
            end
            if (overflow || underflow || ignored_issue) sb_err <= 1'b1;
        end
    end

`ifdef FPU_SB_OPHIST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_fail_cnt <= '0;
        end else if (mismatch) begin
            for (int i = 0; i < 8; i++) begin
                if (head_op == 3'(i))
                    op_fail_cnt[i*CNT_W +: CNT_W] <= sat_inc(op_fail_cnt[i*CNT_W +: CNT_W]);
            end
        end
    end
`endif

    // Verdict FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Verdict FSM: next state. in_end wins over in_valid in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_end)        state_nxt = S_DRAIN;
                else if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (in_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty && (due_pipe == '0)) state_nxt = S_DONE;
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // Verdict FSM: outputs.
    always_comb begin
        done = (state == S_DONE);
        pass = (state == S_DONE) && (fail_cnt == '0) && !sb_err;
    end

endmodule
